conf_int_div__seq__apx: RTL
===========================

# conf_int_div__seq__apx

Sequential restoring integer divider that inverts the configurable-precision multiplier datapath: it takes a double-width product-style dividend and a single-width divisor and returns quotient and remainder. In approximate mode only the top DATA_PATH_BITWIDTH quotient bits are computed, and the low bits are zero-filled, matching the multiplier wrapper's truncation rule. `acc__sel` selects full-precision operation per transaction. The block sits beside the multiplier in the PE, with valid/ready handshakes on both sides.

## Interface
- OP_BITWIDTH, 32, full operand width; divisor, quotient and remainder are this wide, and the dividend is 2*OP_BITWIDTH wide.
- DATA_PATH_BITWIDTH, 16, number of quotient MSBs computed in approximate mode; constraint 1 <= DATA_PATH_BITWIDTH <= OP_BITWIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands.
- a  in  2*OP_BITWIDTH  dividend.
- b  in  OP_BITWIDTH  divisor.
- acc__sel  in  1  1 = full precision, 0 = approximate; sampled only at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- q  out  OP_BITWIDTH  quotient.
- r  out  OP_BITWIDTH  remainder; 0 in approximate mode.
- ovf  out  1  divide overflow or divide-by-zero.
- apx  out  1  result was computed in approximate mode.

## Operation
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE). Accept = in_valid & in_ready.
- On accept, latch b and mode. Latch rem = a[2W-1:W] and shift register = a[W-1:0], where W = OP_BITWIDTH. Set N = OP_BITWIDTH if acc__sel, else N = DATA_PATH_BITWIDTH. Clear the quotient and the step counter.
- Overflow check at accept: if b == 0 or a[2W-1:W] >= b, go directly to DONE with q = all ones, r = 0, ovf = 1, apx = !acc__sel.
- Otherwise go to CALC. Each CALC cycle performs one restoring step, MSB first:
  - t = {rem, next dividend bit}, W+1 bits wide.
  - If t >= b: rem = t - b and the quotient bit is 1.
  - Else: rem = t[W-1:0] and the quotient bit is 0.
  - The counter increments each step. After step N, move to DONE.
- Result in DONE:
  - Accurate mode: q = full quotient, r = rem.
  - Approximate mode: q = {computed N bits, (W-N) zeros}, r = 0, apx = 1.
- In DONE, out_valid = 1 and q, r, ovf, apx are held stable until out_ready. DONE & out_ready moves to IDLE.
- acc__sel, a and b changing outside the accept cycle have no effect.
- Arithmetic is unsigned. No rounding; quotient truncation is toward zero.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, q = 0, r = 0, ovf = 0, apx = 0.
- Latency from the accept edge to out_valid high:
  - accurate: OP_BITWIDTH cycles;
  - approximate: DATA_PATH_BITWIDTH cycles;
  - overflow: 1 cycle.
- Throughput is one transaction per latency + 1 cycles, given out_ready = 1. No overlap: in_ready stays low during CALC and DONE.
- The cycle after the DONE&out_ready handshake: in_ready = 1, out_valid = 0.
- Reset mid-CALC or mid-DONE: the next cycle is IDLE with reset values. The in-flight result is discarded and never presented.
- rst and in_valid asserted in the same cycle: reset wins and no accept occurs.

## Structure
- Package conf_int_div_pkg holds:
  - the state enum typedef (IDLE/CALC/DONE);
  - a localparam for the overflow quotient pattern (all ones);
  - a function computing the step count from the mode bit.
- Sub-module conf_int_div__step: a combinational single restoring step. Inputs are rem, the incoming dividend bit and the divisor; outputs are the new rem and the quotient bit. It is instantiated once inside the sequential top.

## Test plan
All scenarios use W = 32 and DATA_PATH_BITWIDTH = 16.
- a = 64'h0000_0001_0000_0000, b = 3, acc__sel = 1 -> q = 32'h5555_5555, r = 1, ovf = 0, apx = 0, out_valid 32 cycles after accept.
- Same operands with acc__sel = 0 -> q = 32'h5555_0000, r = 0, apx = 1, out_valid 16 cycles after accept.
- b = 0, and separately a = 64'h0000_0005_0000_0000 with b = 5 -> ovf = 1, q = 32'hFFFF_FFFF, r = 0, out_valid 1 cycle after accept.
- a = 1000, b = 7, acc__sel = 1, out_ready held low 5 cycles after out_valid:
  - q = 142 and r = 6, held stable while waiting, with in_ready = 0;
  - out_ready high -> IDLE and in_ready = 1 on the next cycle.
- rst pulsed at CALC step 10 -> the next cycle has out_valid = 0 and in_ready = 1, and no result ever appears for that transaction.
- acc__sel and b toggled every cycle during CALC -> result identical to the first scenario.

Source files
------------

// File: rtl/conf_int_div__seq__apx_pkg.sv
// Shared types and helpers for the sequential restoring divider: FSM states,
// the saturated overflow quotient, and the per-mode step count.
package conf_int_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for any supported operand width; the top slices it down.
  localparam logic [127:0] OVF_Q_ALL_ONES = '1;

  // Number of quotient bits to produce: all of them in full precision,
  // only the datapath-width MSBs in approximate mode.
  function automatic int step_count(input logic acc_sel, input int op_w, input int dp_w);
    return acc_sel ? op_w : dp_w;
  endfunction

endpackage

// File: rtl/conf_int_div__seq__apx_if.sv
// Operand/result bus of the divider: one request channel (a, b, acc__sel)
// and one response channel (q, r, ovf, apx), each with its own handshake.
interface conf_int_div__seq__apx_if #(
  parameter int OP_BITWIDTH = 32
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The producer holds its payload while valid is high and ready
  // is low; the consumer's ready never depends on the payload.
  logic                       in_valid;
  logic                       in_ready;
  logic [2*OP_BITWIDTH-1:0]   a;
  logic [OP_BITWIDTH-1:0]     b;
  logic                       acc__sel;

  logic                       out_valid;
  logic                       out_ready;
  logic [OP_BITWIDTH-1:0]     q;
  logic [OP_BITWIDTH-1:0]     r;
  logic                       ovf;
  logic                       apx;

  modport master (
    output in_valid, a, b, acc__sel, out_ready,
    input  in_ready, out_valid, q, r, ovf, apx
  );

  modport slave (
    input  in_valid, a, b, acc__sel, out_ready,
    output in_ready, out_valid, q, r, ovf, apx
  );

endinterface

// File: rtl/conf_int_div__seq__apx_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module conf_int_div__step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         din_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   t;
  logic [W-1:0] sub;

  always_comb begin
    t     = {rem_i, din_i};
    // rem_i < div_i keeps t - div_i below 2^W, so the low W bits suffice.
    sub   = t[W-1:0] - div_i;
    q_o   = (t >= {1'b0, div_i});
    rem_o = q_o ? sub : t[W-1:0];
  end

endmodule

// File: rtl/conf_int_div__seq__apx.sv
// Sequential restoring divider (2W / W -> W quotient, W remainder) with an
// approximate mode that only resolves the top DATA_PATH_BITWIDTH quotient bits.
module conf_int_div__seq__apx
  import conf_int_div_pkg::*;
#(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  conf_int_div__seq__apx_if.slave   bus,
  output state_e                    state_dbg
);

  localparam int W  = OP_BITWIDTH;
  localparam int CW = $clog2(OP_BITWIDTH + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    b_q, b_d;
  logic            acc_q, acc_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   n_q, n_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    r_q, r_d;
  logic            ovf_q, ovf_d;
  logic            apx_q, apx_d;

  logic [W-1:0]    step_rem_in;
  logic            step_bit_in;
  logic [W-1:0]    step_div_in;
  logic [W-1:0]    step_rem;
  logic            step_q;
  logic            finish;

  // The first step runs in the accept cycle on the raw operands, so the
  // result is ready exactly N cycles after the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      step_rem_in = bus.a[2*W-1:W];
      step_bit_in = bus.a[W-1];
      step_div_in = bus.b;
    end else begin
      step_rem_in = rem_q;
      step_bit_in = shift_q[W-1];
      step_div_in = b_q;
    end
  end

  conf_int_div__step #(.W(W)) u_step (
    .rem_i (step_rem_in),
    .din_i (step_bit_in),
    .div_i (step_div_in),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    apx_d   = apx_q;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          b_d   = bus.b;
          acc_d = bus.acc__sel;
          n_d   = CW'(step_count(bus.acc__sel, OP_BITWIDTH, DATA_PATH_BITWIDTH));
          if ((bus.b == '0) || (bus.a[2*W-1:W] >= bus.b)) begin
            // Quotient would not fit in W bits (or divisor is zero).
            state_d = DONE;
            rem_d   = '0;
            shift_d = '0;
            quo_d   = '0;
            cnt_d   = '0;
            q_d     = OVF_Q_ALL_ONES[W-1:0];
            r_d     = '0;
            ovf_d   = 1'b1;
            apx_d   = !bus.acc__sel;
          end else begin
            state_d = CALC;
            rem_d   = step_rem;
            shift_d = bus.a[W-1:0] << 1;
            quo_d   = W'(step_q);
            cnt_d   = CW'(1);
            finish  = (n_d == CW'(1));
          end
        end
      end

      CALC: begin
        rem_d   = step_rem;
        shift_d = shift_q << 1;
        quo_d   = (quo_q << 1) | W'(step_q);
        cnt_d   = cnt_q + CW'(1);
        finish  = (cnt_d == n_q);
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Left-justify the N computed bits; in full precision the shift is zero.
    if (finish) begin
      state_d = DONE;
      q_d     = quo_d << (CW'(W) - n_d);
      r_d     = acc_d ? rem_d : '0;
      ovf_d   = 1'b0;
      apx_d   = !acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      acc_q   <= 1'b0;
      rem_q   <= '0;
      shift_q <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      apx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      apx_q   <= apx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.ovf       = ovf_q;
  assign bus.apx       = apx_q;
  assign state_dbg     = state_q;

endmodule
